fsm_vedacao: RTL and testbench

Slave FSM for the sealing (vedação) station. It receives the sealing command level from the master sequencer and drives the sealing actuator for a fixed time. It returns a one-cycle completion pulse and owns the cork (rolha) stock counter. It generates the alarme_rolha level that the master sequencer uses to pause the line, and accepts operator refill pulses.

---
 rtl/fsm_vedacao_if.sv | 30 +++
 rtl/fsm_vedacao.sv | 144 ++++++++++++++
 tb/tb_fsm_vedacao.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fsm_vedacao_if.sv
// Handshake bundle between the master sequencer and the sealing station.
// W must equal $clog2(ESTOQUE_MAX+1) of the attached fsm_vedacao.
interface fsm_vedacao_if #(
    parameter int W = 5
);
    logic         cmd_vedar;
    logic         recarga;
    logic         atuador_vedacao;
    logic         vedacao_concluida;
    logic         alarme_rolha;
    logic [W-1:0] estoque_rolhas;

    modport master (
        output cmd_vedar,
        output recarga,
        input  atuador_vedacao,
        input  vedacao_concluida,
        input  alarme_rolha,
        input  estoque_rolhas
    );

    modport slave (
        input  cmd_vedar,
        input  recarga,
        output atuador_vedacao,
        output vedacao_concluida,
        output alarme_rolha,
        output estoque_rolhas
    );
endinterface

// File: rtl/fsm_vedacao.sv
// Sealing station slave FSM: timed actuator, cork stock counter and low-stock alarm.
// Optional automatic refill after a long idle-at-zero period: macro RECARGA_AUTOMATICA_EN.
module fsm_vedacao #(
    parameter int ESTOQUE_MAX        = 20,
    parameter int ESTOQUE_INICIAL    = 10,
    parameter int RECARGA_QTD        = 15,
    parameter int TEMPO_VEDACAO      = 50000000,
    parameter int TEMPO_RECARGA_AUTO = 100000000,
    localparam int W = $clog2(ESTOQUE_MAX + 1)
) (
    input logic          clk,
    input logic          reset,
    fsm_vedacao_if.slave bus
);

    localparam int TW         = (TEMPO_VEDACAO > 1) ? $clog2(TEMPO_VEDACAO) : 1;
    // Clamping the refill amount to capacity keeps the W+1 bit sum from overflowing.
    localparam int RECARGA_EF = (RECARGA_QTD > ESTOQUE_MAX) ? ESTOQUE_MAX : RECARGA_QTD;

    localparam logic [TW-1:0] TIMER_FIM    = TW'(TEMPO_VEDACAO - 1);
    localparam logic [W:0]    RECARGA_SOMA = (W+1)'(RECARGA_EF);
    localparam logic [W:0]    LIMITE       = (W+1)'(ESTOQUE_MAX);
    localparam logic [W-1:0]  INICIAL      = W'(ESTOQUE_INICIAL);

    if (TEMPO_VEDACAO < 1 || ESTOQUE_INICIAL > ESTOQUE_MAX || TEMPO_RECARGA_AUTO < 1) begin : g_parametros_invalidos
        $error("fsm_vedacao: invalid parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        VEDANDO       = 3'd1,
        CONCLUIDO     = 3'd2,
        ESPERA_LIBERA = 3'd3,
        SEM_ROLHA     = 3'd4
    } estado_t;

    estado_t        estado, estado_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    logic [W-1:0]   estoque, estoque_nxt;
    logic [W:0]     soma;
    logic           consome;
    logic           recarga_auto;
    logic           atuador_q, concluida_q, alarme_q;

    always_comb begin
        estado_nxt = estado;
        timer_nxt  = timer;
        consome    = 1'b0;
        case (estado)
            IDLE: begin
                if (bus.cmd_vedar) begin
                    if (estoque != '0) begin
                        estado_nxt = VEDANDO;
                        consome    = 1'b1;
                    end else begin
                        estado_nxt = SEM_ROLHA;
                    end
                end
            end
            // Abort wins over completion; the consumed cork is not returned.
            VEDANDO: begin
                if (!bus.cmd_vedar) begin
                    estado_nxt = IDLE;
                    timer_nxt  = '0;
                end else if (timer == TIMER_FIM) begin
                    estado_nxt = CONCLUIDO;
                    timer_nxt  = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            CONCLUIDO: estado_nxt = ESPERA_LIBERA;
            ESPERA_LIBERA: begin
                if (!bus.cmd_vedar) estado_nxt = IDLE;
            end
            SEM_ROLHA: begin
                if (estoque != '0) begin
                    if (bus.cmd_vedar) begin
                        estado_nxt = VEDANDO;
                        consome    = 1'b1;
                    end else begin
                        estado_nxt = IDLE;
                    end
                end
            end
            default: begin
                estado_nxt = IDLE;
                timer_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        soma = {1'b0, estoque} - {{W{1'b0}}, consome} + (bus.recarga ? RECARGA_SOMA : '0);
        if (soma > LIMITE) estoque_nxt = W'(ESTOQUE_MAX);
        else               estoque_nxt = soma[W-1:0];
        if (recarga_auto)  estoque_nxt = W'(RECARGA_EF);
    end

`ifdef RECARGA_AUTOMATICA_EN
    localparam int AW = (TEMPO_RECARGA_AUTO > 1) ? $clog2(TEMPO_RECARGA_AUTO) : 1;
    localparam logic [AW-1:0] AUTO_FIM = AW'(TEMPO_RECARGA_AUTO - 1);

    logic [AW-1:0] auto_cnt;
    logic          ocioso_vazio;

    // A manual refill counts as leaving the idle-at-zero condition.
    assign ocioso_vazio = (estado == IDLE) && (estoque == '0) && !bus.recarga;
    assign recarga_auto = ocioso_vazio && (auto_cnt == AUTO_FIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              auto_cnt <= '0;
        else if (!ocioso_vazio || recarga_auto)  auto_cnt <= '0;
        else                                     auto_cnt <= auto_cnt + 1'b1;
    end
`else
    assign recarga_auto = 1'b0;
`endif

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado      <= IDLE;
            timer       <= '0;
            estoque     <= INICIAL;
            atuador_q   <= 1'b0;
            concluida_q <= 1'b0;
            alarme_q    <= (ESTOQUE_INICIAL == 0);
        end else begin
            estado      <= estado_nxt;
            timer       <= timer_nxt;
            estoque     <= estoque_nxt;
            atuador_q   <= (estado_nxt == VEDANDO);
            concluida_q <= (estado_nxt == CONCLUIDO);
            alarme_q    <= (estoque_nxt == '0);
        end
    end

    assign bus.atuador_vedacao   = atuador_q;
    assign bus.vedacao_concluida = concluida_q;
    assign bus.alarme_rolha      = alarme_q;
    assign bus.estoque_rolhas    = estoque;

endmodule

// File: tb/tb_fsm_vedacao.sv
// Scoreboard bench for fsm_vedacao: a cycle model pushes expected outputs, checked after each edge.
// Build with RECARGA_AUTOMATICA_EN defined to exercise the automatic refill path as well.
module tb_fsm_vedacao;

    localparam int T    = 4;
    localparam int MAX  = 5;
    localparam int INI  = 2;
    localparam int RQ   = 3;
    localparam int AUTO = 8;
    localparam int W    = 3;

    localparam int M_IDLE  = 0;
    localparam int M_SEAL  = 1;
    localparam int M_DONE  = 2;
    localparam int M_WAIT  = 3;
    localparam int M_EMPTY = 4;

    typedef struct {
        logic         act;
        logic         conc;
        logic         alm;
        logic [W-1:0] est;
    } exp_t;

    logic clk;
    logic reset;
    int   errorCount;
    int   checkCount;
    int   mState;
    int   mLeft;
    int   mStock;
    int   mAuto;
    exp_t scoreboard[$];

    fsm_vedacao_if #(.W(W)) bus ();

    fsm_vedacao #(
        .ESTOQUE_MAX       (MAX),
        .ESTOQUE_INICIAL   (INI),
        .RECARGA_QTD       (RQ),
        .TEMPO_VEDACAO     (T),
        .TEMPO_RECARGA_AUTO(AUTO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        e.act  = (mState == M_SEAL);
        e.conc = (mState == M_DONE);
        e.alm  = (mStock == 0);
        e.est  = mStock[W-1:0];
        scoreboard.push_back(e);
    endtask

    task automatic compareHead(input string tag);
        exp_t e;
        e = scoreboard.pop_front();
        checkOutput({tag, ".atuador"},   int'(bus.atuador_vedacao),   int'(e.act));
        checkOutput({tag, ".concluida"}, int'(bus.vedacao_concluida), int'(e.conc));
        checkOutput({tag, ".alarme"},    int'(bus.alarme_rolha),      int'(e.alm));
        checkOutput({tag, ".estoque"},   int'(bus.estoque_rolhas),    int'(e.est));
    endtask

    task automatic modelReset();
        mState = M_IDLE;
        mLeft  = 0;
        mStock = INI;
        mAuto  = 0;
    endtask

    task automatic modelStep(input logic cmd, input logic rec);
        int  s;
        int  dec;
        bit  autoLoad;
        dec      = 0;
        autoLoad = 0;
`ifdef RECARGA_AUTOMATICA_EN
        if (mState == M_IDLE && mStock == 0 && !rec) begin
            if (mAuto == AUTO - 1) begin
                autoLoad = 1;
                mAuto    = 0;
            end else begin
                mAuto++;
            end
        end else begin
            mAuto = 0;
        end
`endif
        case (mState)
            M_IDLE: begin
                if (cmd && mStock > 0) begin
                    mState = M_SEAL; mLeft = T; dec = 1;
                end else if (cmd) begin
                    mState = M_EMPTY;
                end
            end
            M_SEAL: begin
                if (!cmd)            mState = M_IDLE;
                else if (mLeft == 1) mState = M_DONE;
                else                 mLeft--;
            end
            M_DONE: mState = M_WAIT;
            M_WAIT: if (!cmd) mState = M_IDLE;
            default: begin
                if (mStock > 0 && cmd) begin
                    mState = M_SEAL; mLeft = T; dec = 1;
                end else if (mStock > 0) begin
                    mState = M_IDLE;
                end
            end
        endcase
        s = mStock - dec + (rec ? RQ : 0);
        if (s > MAX) s = MAX;
        if (autoLoad) s = (RQ < MAX) ? RQ : MAX;
        mStock = s;
        pushExpected();
    endtask

    // Called between edges; drives one cycle of inputs and checks the result after the edge.
    task automatic applyStimulus(input logic cmd, input logic rec, input string tag);
        bus.cmd_vedar = cmd;
        bus.recarga   = rec;
        modelStep(cmd, rec);
        @(posedge clk);
        #1;
        compareHead(tag);
    endtask

    task automatic doSeal(input int holdCycles, input int relCycles, input string tag);
        for (int i = 0; i < holdCycles; i++) applyStimulus(1'b1, 1'b0, tag);
        for (int i = 0; i < relCycles; i++)  applyStimulus(1'b0, 1'b0, tag);
    endtask

    task automatic applyReset(input string tag);
        #2;
        reset         = 1'b0;
        bus.cmd_vedar = 1'b0;
        bus.recarga   = 1'b0;
        #1;
        modelReset();
        pushExpected();
        compareHead({tag, ".async"});
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            pushExpected();
            compareHead({tag, ".held"});
        end
        #2;
        reset = 1'b1;
    endtask

    initial begin
        errorCount    = 0;
        checkCount    = 0;
        reset         = 1'b0;
        bus.cmd_vedar = 1'b0;
        bus.recarga   = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        applyReset("reset");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, "idle");

        // One seal with the command held long after completion.
        doSeal(1 + T + 1 + 20, 2, "seal1");
        doSeal(T + 3, 2, "seal2");

        // Out of corks: command parks in SEM_ROLHA until a refill arrives.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, "semRolha");
        applyStimulus(1'b1, 1'b1, "semRolhaRecarga");
        doSeal(T + 2, 2, "sealAposRecarga");

        // Saturation at the magazine limit.
        doSeal(T + 3, 2, "seal3");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, "recargaSat");
        for (int i = 0; i < 4; i++) doSeal(T + 3, 2, "drena");

        // Seal start and refill on the same edge.
        applyStimulus(1'b1, 1'b1, "simultaneo");
        doSeal(T + 2, 2, "simultaneoFim");

        // Abort during the second actuator cycle.
        doSeal(2, 4, "abort");

        // Asynchronous reset in the middle of a seal.
        doSeal(2, 0, "preReset");
        applyReset("resetMeio");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, "posReset");

        // Idle at zero stock, with and without automatic refill.
        doSeal(T + 3, 2, "esvazia1");
        doSeal(T + 3, 2, "esvazia2");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, "zeroOcioso");
        applyStimulus(1'b0, 1'b1, "recargaManual");
        for (int i = 0; i < 3; i++) doSeal(T + 3, 2, "esvazia3");
        for (int i = 0; i < AUTO + 4; i++) applyStimulus(1'b0, 1'b0, "autoRecarga");
        doSeal(T + 3, 2, "sealFinal");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
